// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one shared memory bus.
// Data wins ties unless the fetch port has been starved STARVE_LIMIT times; a watchdog aborts hung accesses.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT, DONE} state_t;

  localparam logic [2:0] STARVE_MAX  = 3'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_reg, state_next;
  logic [2:0]  starve_cnt_reg;
  logic [7:0]  wait_cnt_reg;
  logic        grant_if, grant_dm, in_wait, timeout_hit, finish;

  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    timeout_hit = 1'b0;
    finish      = 1'b0;
    in_wait     = (state_reg == IF_WAIT) || (state_reg == DM_WAIT);
    case (state_reg)
      IDLE: begin
        if (if_req_i && (!dm_req_i || starve_cnt_reg == STARVE_MAX)) begin
          grant_if   = 1'b1;
          state_next = IF_WAIT;
        end else if (dm_req_i) begin
          grant_dm   = 1'b1;
          state_next = DM_WAIT;
        end
      end
      IF_WAIT, DM_WAIT: begin
        // A real acknowledge always beats the watchdog in the same cycle.
        timeout_hit = !mem_ack_i && (wait_cnt_reg == TIMEOUT_CNT);
        finish      = mem_ack_i || timeout_hit;
        if (finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt_reg <= '0;
      wait_cnt_reg   <= '0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      if_rdata_o     <= '0;
      dm_rdata_o     <= '0;
      if_ack_o       <= 1'b0;
      dm_ack_o       <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;

      // Only data grants made while a fetch is waiting count towards starvation.
      if (state_reg == IDLE && !if_req_i)
        starve_cnt_reg <= '0;
      else if (grant_if)
        starve_cnt_reg <= '0;
      else if (grant_dm && starve_cnt_reg != 3'd7)
        starve_cnt_reg <= starve_cnt_reg + 3'd1;

      if (grant_if || grant_dm) begin
        mem_req_o    <= 1'b1;
        mem_we_o     <= grant_dm & dm_we_i;
        mem_addr_o   <= grant_dm ? dm_addr_i : if_addr_i;
        mem_wdata_o  <= grant_dm ? dm_wdata_i : '0;
        wait_cnt_reg <= '0;
      end

      if (in_wait && !finish)
        wait_cnt_reg <= wait_cnt_reg + 8'd1;

      if (finish) begin
        mem_req_o <= 1'b0;
        mem_we_o  <= 1'b0;
        if (timeout_hit) err_o <= 1'b1;
        if (state_reg == IF_WAIT) begin
          if_ack_o   <= 1'b1;
          if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
        end else begin
          dm_ack_o <= 1'b1;
          // Writes leave the data read register untouched, even on abort.
          if (!mem_we_o) dm_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while an instruction-port request waits.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles spent waiting for mem_ack_i before abort; 8-bit.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset; asynchronous and active-low.
REQ-005 if_req_i  in  1  instruction-fetch request; held high until if_ack_o.
REQ-006 if_addr_i  in  32  fetch address.
REQ-007 if_rdata_o  out  32  fetched instruction; valid when if_ack_o is high.
REQ-008 if_ack_o  out  1  one-cycle completion pulse for the fetch port.
REQ-009 dm_req_i  in  1  data request; held high until dm_ack_o.
REQ-010 dm_we_i  in  1  1 = write, 0 = read.
REQ-011 dm_addr_i  in  32  data address.
REQ-012 dm_wdata_i  in  32  write data.
REQ-013 dm_rdata_o  out  32  read data; valid when dm_ack_o is high on a read.
REQ-014 dm_ack_o  out  1  one-cycle completion pulse for the data port.
REQ-015 mem_req_o  out  1  request to the shared memory; held high until mem_ack_i.
REQ-016 mem_we_o  out  1  write enable to memory.
REQ-017 mem_addr_o  out  32  latched address.
REQ-018 mem_wdata_o  out  32  latched write data.
REQ-019 mem_ack_i  in  1  memory completion pulse; mem_rdata_i is valid in the same cycle.
REQ-020 mem_rdata_i  in  32  memory read data.
REQ-021 stall_o  out  1  pipeline stall to the hazard logic: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
REQ-022 err_o  out  1  sticky timeout flag.

Function
REQ-023 FSM states: IDLE, IF_WAIT, DM_WAIT, DONE.
REQ-024 IDLE with any request: the arbiter grants at the next edge, moves to the matching *_WAIT state, latches address, write data and we into mem_*_o, and asserts mem_req_o from that edge.
REQ-025 Priority: the data port wins simultaneous requests unless starve_cnt == STARVE_LIMIT, in which case the instruction port wins.
REQ-026 starve_cnt (3-bit):
- increments, saturating, on each data grant while if_req_i is high;
- clears on an instruction grant;
- clears in any IDLE cycle with if_req_i low.
REQ-027 *_WAIT: mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o hold stable until a cycle with mem_ack_i high.
REQ-028 On mem_ack_i: the arbiter registers mem_rdata_i into the granted port's rdata register (not for writes), goes to DONE, and deasserts mem_req_o at that edge.
REQ-029 DONE lasts exactly one cycle:
- the granted port's ack output is high for that cycle only;
- the next state is always IDLE, so no arbitration happens in DONE.
REQ-030 Latency: mem_req_o rises 1 cycle after a request is sampled in IDLE, and ack rises 1 cycle after mem_ack_i. The minimum access is memory latency + 2 cycles, and back-to-back accesses are separated by one IDLE cycle.
REQ-031 rdata outputs hold their last value outside ack cycles; dm_rdata_o is unchanged by writes.
REQ-032 Watchdog:
- a wait counter clears on entry to *_WAIT and increments each cycle in *_WAIT;
- at count == TIMEOUT with no mem_ack_i, the arbiter drops mem_req_o, sets err_o, loads 0 into the granted port's rdata, and goes to DONE (ack still pulses).
REQ-033 mem_ack_i has precedence over timeout in the same cycle.
REQ-034 mem_ack_i outside *_WAIT is ignored.
REQ-035 A requester dropping its request during *_WAIT does not abort the access; the transaction completes and ack still pulses.
REQ-036 err_o remains high until reset.

Reset
REQ-037 rst_i low immediately (asynchronously) forces:
- state IDLE; starve_cnt and wait counter 0;
- mem_req_o, mem_we_o, if_ack_o, dm_ack_o and err_o to 0;
- mem_addr_o, mem_wdata_o, if_rdata_o and dm_rdata_o to 0.
REQ-038 Reset mid-access abandons the transaction without an ack; the first grant may occur on the first rising edge after rst_i returns high.

Verification
REQ-039 if_req_i=1, if_addr_i=0x10, memory acks after 3 cycles with 0x00A00093 -> mem_req_o high 3 cycles, if_ack_o pulses once with if_rdata_o=0x00A00093, stall_o low in the ack cycle.
REQ-040 if_req_i and dm_req_i rise together, dm read 0x100 -> data granted first, dm_ack_o pulses, then fetch granted after one IDLE cycle; stall_o high throughout until the final ack.
REQ-041 dm_req_i continuously high, if_req_i high, default STARVE_LIMIT -> 4 data grants, the 5th grant goes to the fetch port, starve_cnt returns to 0.
REQ-042 dm write 0xDEADBEEF to 0x20 -> mem_we_o=1, mem_wdata_o=0xDEADBEEF for the whole wait, dm_ack_o pulses, dm_rdata_o unchanged.
REQ-043 mem_ack_i never arrives -> abort after 255 wait cycles, ack pulses with rdata 0, err_o set and still high 10 cycles later.
REQ-044 rst_i low in the second cycle of DM_WAIT -> mem_req_o 0 immediately, no dm_ack_o, new request after release granted normally.
